// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock: measures period/high time of div_clk_in
// in clk_in cycles, tracks lock, and flags period, duty and stuck faults.
module clk_div_monitor #(
  parameter int DIV_RATIO  = 6,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_clk_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             period_err,
  output logic             duty_err,
  output logic             stuck_err
);

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(2 * DIV_RATIO);
  localparam logic [CNT_W-1:0] PER  = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HMIN = CNT_W'(DIV_RATIO / 2);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'((DIV_RATIO + 1) / 2);
  localparam logic [GW-1:0]    LAST = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t           state, state_n;
  logic [GW-1:0]    good, good_n;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic             d_q, rise, p_bad, d_bad;
  logic             locked_n, meas_n, perr_n, derr_n, stuck_n;

  assign rise  = div_clk_in & ~d_q;
  assign p_bad = (pcnt != PER);
  assign d_bad = (hcnt < HMIN) || (hcnt > HMAX);

  always_comb begin
    state_n  = state;
    good_n   = good;
    locked_n = locked;
    meas_n   = 1'b0;
    perr_n   = 1'b0;
    derr_n   = 1'b0;
    stuck_n  = 1'b0;
    case (state)
      IDLE: begin
        // First edge only establishes the reference; nothing to measure yet.
        if (rise) begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (rise) begin
          meas_n = 1'b1;
          perr_n = p_bad;
          derr_n = d_bad;
          if (p_bad || d_bad) begin
            state_n  = ACQUIRE;
            good_n   = '0;
            locked_n = 1'b0;
          end else if (state == ACQUIRE) begin
            good_n = good + 1'b1;
            if (good == LAST) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end
        end else if (pcnt == SAT) begin
          // Dropping to IDLE disarms the timeout until the next edge.
          stuck_n  = 1'b1;
          locked_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      good       <= '0;
      pcnt       <= '0;
      hcnt       <= '0;
      d_q        <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
      duty_err   <= 1'b0;
      stuck_err  <= 1'b0;
    end else begin
      state      <= state_n;
      good       <= good_n;
      d_q        <= div_clk_in;
      meas_valid <= meas_n;
      locked     <= locked_n;
      period_err <= perr_n;
      duty_err   <= derr_n;
      stuck_err  <= stuck_n;
      if (rise) pcnt <= CNT_W'(1);
      else if (pcnt != SAT) pcnt <= pcnt + 1'b1;
      if (rise) hcnt <= CNT_W'(1);
      else if (hcnt != SAT) hcnt <= hcnt + {{(CNT_W-1){1'b0}}, div_clk_in};
      if (meas_n) begin
        period_out <= pcnt;
        high_out   <= hcnt;
      end
    end
  end

endmodule
